// File: rtl/mc_pkg.sv
// mc_pkg: state, opcode and control-field encodings for the multicycle MIPS controller.
// The ADDIEX/ADDIWB states exist only when MC_ADDI_EN is defined.
package mc_pkg;
  typedef logic [3:0] stateT;
  localparam stateT ST_FETCH  = 4'd0;
  localparam stateT ST_DECODE = 4'd1;
  localparam stateT ST_MEMADR = 4'd2;
  localparam stateT ST_MEMRD  = 4'd3;
  localparam stateT ST_MEMWB  = 4'd4;
  localparam stateT ST_MEMWR  = 4'd5;
  localparam stateT ST_EXEC   = 4'd6;
  localparam stateT ST_ALUWB  = 4'd7;
  localparam stateT ST_BRANCH = 4'd8;
  localparam stateT ST_JUMP   = 4'd9;
`ifdef MC_ADDI_EN
  localparam stateT ST_ADDIEX = 4'd10;
  localparam stateT ST_ADDIWB = 4'd11;
`endif
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
endpackage

// File: rtl/mc_out_decode.sv
// mc_out_decode: combinational state -> control-word decoder; FETCH write enables gated by mem_ready.
// Decodes ADDIEX/ADDIWB when MC_ADDI_EN is defined.
module mc_out_decode
  import mc_pkg::*;
(
  input  stateT      state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source
);
  always_comb begin
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    ir_write = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst = 1'b0;
    reg_write = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = SRCB_B;
    alu_op = ALUOP_ADD;
    pc_source = PCSRC_ALU;
    case (state)
      ST_FETCH: begin
        mem_read = 1'b1;
        alu_src_b = SRCB_FOUR;
        pc_write = mem_ready;
        ir_write = mem_ready;
      end
      ST_DECODE: alu_src_b = SRCB_IMMSH;
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        i_or_d = 1'b1;
      end
      ST_MEMWB: begin
        reg_write = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        mem_write = 1'b1;
        i_or_d = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`ifdef MC_ADDI_EN
      ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_ADDIWB: reg_write = 1'b1;
`endif
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for a shared-memory multicycle MIPS datapath with memory wait-state timeout.
// Define MC_ADDI_EN to decode addi (opcode 001000) instead of flagging it illegal.
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       bus_timeout
);
  localparam int CNT_W = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);
  stateT state, nextState;
  logic [CNT_W-1:0] waitCnt;
  logic waiting, timeout, illegal, busTimeout;
  assign waiting = (state == ST_FETCH) || (state == ST_MEMRD) || (state == ST_MEMWR);
  // Abort on the MEM_WAIT_MAX-th consecutive not-ready cycle; mem_ready is low so no write fires.
  assign timeout = (MEM_WAIT_MAX != 0) && waiting && !mem_ready && (waitCnt == LAST_WAIT);
  always_comb begin
    nextState = ST_FETCH;
    illegal = 1'b0;
    case (state)
      ST_FETCH: nextState = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:
        case (opcode)
          OP_LW, OP_SW: nextState = ST_MEMADR;
          OP_RTYPE: nextState = ST_EXEC;
          OP_BEQ: nextState = ST_BRANCH;
          OP_J: nextState = ST_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI: nextState = ST_ADDIEX;
`endif
          default: illegal = 1'b1;
        endcase
      ST_MEMADR: nextState = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD: nextState = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR: nextState = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC: nextState = ST_ALUWB;
`ifdef MC_ADDI_EN
      ST_ADDIEX: nextState = ST_ADDIWB;
`endif
      default: nextState = ST_FETCH;
    endcase
    if (timeout) nextState = ST_FETCH;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      waitCnt <= '0;
      busTimeout <= 1'b0;
    end else begin
      state <= nextState;
      waitCnt <= (waiting && !mem_ready && !timeout) ? waitCnt + 1'b1 : '0;
      if (timeout) busTimeout <= 1'b1;
    end
  end
  // During reset the outputs show FETCH with its ready-gated writes suppressed.
  mc_out_decode u_decode (
    .state(reset ? ST_FETCH : state),
    .mem_ready(mem_ready & ~reset),
    .pc_write(pc_write),
    .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst),
    .reg_write(reg_write),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_source(pc_source)
  );
  assign illegal_op = illegal & ~reset;
  assign bus_timeout = busTimeout;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed plus random instruction streams checked against a per-opcode phase model.
// Expects addi to be legal only when MC_ADDI_EN is defined.
module tb_multicycle_ctrl;
  logic clk = 1'b0, reset = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, bus_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  typedef enum {P_FETCH, P_DECODE, P_ILLEGAL, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_EXEC, P_ALUWB, P_BRANCH, P_JUMP, P_ADDIEX, P_ADDIWB} phaseT;
  typedef struct packed {
    logic pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
    logic memToReg, regDst, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic illegal;
  } ctlT;
  typedef struct {phaseT p; logic rdy;} stepT;

  stepT q[$];
  int nCmp = 0, nBad = 0;
  logic expBt = 1'b0;
  logic [5:0] curOp = 6'd0;
  ctlT obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op};

  function automatic ctlT expWord(input phaseT p, input logic rdy);
    ctlT c = '0;
    case (p)
      P_FETCH:   begin c.memRead = 1; c.aluSrcB = 2'b01; c.irWrite = rdy; c.pcWrite = rdy; end
      P_DECODE:  c.aluSrcB = 2'b11;
      P_ILLEGAL: begin c.aluSrcB = 2'b11; c.illegal = 1; end
      P_MEMADR:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      P_MEMRD:   begin c.memRead = 1; c.iOrD = 1; end
      P_MEMWB:   begin c.regWrite = 1; c.memToReg = 1; end
      P_MEMWR:   begin c.memWrite = 1; c.iOrD = 1; end
      P_EXEC:    begin c.aluSrcA = 1; c.aluOp = 2'b10; end
      P_ALUWB:   begin c.regWrite = 1; c.regDst = 1; end
      P_BRANCH:  begin c.aluSrcA = 1; c.aluOp = 2'b01; c.pcWriteCond = 1; c.pcSource = 2'b01; end
      P_JUMP:    begin c.pcWrite = 1; c.pcSource = 2'b10; end
      P_ADDIEX:  begin c.aluSrcA = 1; c.aluSrcB = 2'b10; end
      P_ADDIWB:  c.regWrite = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit isLegal(input logic [5:0] op);
`ifdef MC_ADDI_EN
    if (op == 6'b001000) return 1;
`endif
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010};
  endfunction

  task automatic check(input ctlT exp, input logic bt, input string tag);
    nCmp++;
    assert (obs === exp && bus_timeout === bt) else begin
      nBad++;
      $error("FAIL %s: observed ctl=%h bus_timeout=%b, expected ctl=%h bus_timeout=%b", tag, obs, bus_timeout, exp, bt);
    end
  endtask

  task automatic push(input phaseT p);
    q.push_back('{p, 1'($urandom)});
  endtask

  task automatic addWait(input phaseT p, input int waits);
    repeat (waits) q.push_back('{p, 1'b0});
    q.push_back('{p, 1'b1});
  endtask

  task automatic addInstr(input logic [5:0] op, input int w0, input int w1);
    curOp = op;
    addWait(P_FETCH, w0);
    if (!isLegal(op)) push(P_ILLEGAL);
    else begin
      push(P_DECODE);
      case (op)
        6'b100011: begin push(P_MEMADR); addWait(P_MEMRD, w1); push(P_MEMWB); end
        6'b101011: begin push(P_MEMADR); addWait(P_MEMWR, w1); end
        6'b000000: begin push(P_EXEC); push(P_ALUWB); end
        6'b000100: push(P_BRANCH);
        6'b000010: push(P_JUMP);
        default:   begin push(P_ADDIEX); push(P_ADDIWB); end
      endcase
    end
  endtask

  task automatic runQueue(input string tag);
    stepT s;
    while (q.size() > 0) begin
      s = q.pop_front();
      mem_ready = s.rdy;
      opcode = (s.p == P_FETCH) ? 6'($urandom) : curOp;
      @(negedge clk);
      check(expWord(s.p, s.rdy), expBt, tag);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset(input string tag);
    reset = 1'b1;
    mem_ready = 1'b1;
    opcode = 6'($urandom);
    @(posedge clk);
    #1;
    @(negedge clk);
    check(expWord(P_FETCH, 1'b0), 1'b0, tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expBt = 1'b0;
  endtask

  initial begin
    logic [5:0] op;
    doReset("reset");
    addInstr(6'b100011, 0, 0); runQueue("lw");
    addInstr(6'b000000, 0, 0); runQueue("rtype");
    addInstr(6'b000100, 0, 0); runQueue("beq");
    addInstr(6'b101011, 0, 3); runQueue("sw_wait");
    addInstr(6'b111111, 0, 0); runQueue("illegal");
    addInstr(6'b001000, 1, 0); runQueue("addi");
    addInstr(6'b000010, 2, 0); runQueue("jump");
    repeat (15) q.push_back('{P_FETCH, 1'b0});
    runQueue("fetch_timeout");
    expBt = 1'b1;
    repeat (3) q.push_back('{P_FETCH, 1'b0});
    runQueue("timeout_sticky");
    addInstr(6'b100011, 0, 0); runQueue("after_timeout");
    doReset("reset_clears_timeout");
    curOp = 6'b100011;
    addWait(P_FETCH, 0); push(P_DECODE); push(P_MEMADR);
    repeat (15) q.push_back('{P_MEMRD, 1'b0});
    runQueue("memrd_timeout");
    expBt = 1'b1;
    addInstr(6'b000000, 0, 0); runQueue("after_memrd_timeout");
    doReset("reset2");
    curOp = 6'b101011;
    addWait(P_FETCH, 0); push(P_DECODE); push(P_MEMADR);
    repeat (15) q.push_back('{P_MEMWR, 1'b0});
    runQueue("memwr_timeout");
    expBt = 1'b1;
    addInstr(6'b000100, 0, 0); runQueue("after_memwr_timeout");
    doReset("reset3");
    curOp = 6'b100011;
    addWait(P_FETCH, 0); push(P_DECODE); push(P_MEMADR);
    repeat (2) q.push_back('{P_MEMRD, 1'b0});
    runQueue("pre_reset_memrd");
    doReset("reset_mid_memrd");
    addInstr(6'b000000, 0, 0); runQueue("after_mid_reset");
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(6))
        0: op = 6'b100011;
        1: op = 6'b101011;
        2: op = 6'b000000;
        3: op = 6'b000100;
        4: op = 6'b000010;
        5: op = 6'b001000;
        default: begin
          op = 6'($urandom);
          while (isLegal(op) || op == 6'b001000) op = 6'($urandom);
        end
      endcase
      addInstr(op, $urandom_range(4), $urandom_range(4));
      runQueue("random");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end
endmodule
